alu_op_sequencer: RTL and testbench
===================================

// Module: alu_op_sequencer
// PURPOSE
//   Multi-cycle controller that sequences the shared n-bit ALU and the register file for one instruction at a time.
//   Accepts an instruction word over a valid/ready handshake and decodes it.
//   Drives register-file read/write addresses, ALU op/en/mov_sel and the writeback strobe.
//   Holds the architectural O/Z/N flags and resolves flag-conditional branches for the PC logic.
// PARAMETERS
//   AW          3   register-file address width; instruction width IW = 4 + 3*AW + 1 (14 at default)
//   EXEC_CYCLES 1   cycles alu_en is held before writeback (>=1; values <1 treated as 1)
// PORTS
//   clk          in   1        system clock, all logic on rising edge
//   rst          in   1        synchronous, active-high reset
//   instr_valid  in   1        instruction word present
//   instr_ready  out  1        sequencer can accept an instruction
//   instr        in   IW       [IW-1:IW-4] opcode, then rd, ra, rb (AW each, MSB first), [0] mov_sel
//   rf_ra        out  AW       register-file read address A
//   rf_rb        out  AW       register-file read address B
//   rf_rd        out  AW       register-file write address
//   rf_we        out  1        register-file write strobe (1-cycle pulse)
//   alu_op       out  3        ALU operation select
//   alu_en       out  1        ALU enable
//   alu_mov_sel  out  1        ALU move source (0=A, 1=B)
//   alu_o/alu_z/alu_n in 1 each ALU overflow/zero/negative outputs
//   flag_o/flag_z/flag_n out 1 each registered architectural flags
//   pc_load      out  1        1-cycle pulse: branch taken
//   pc_offset    out  IW-4     branch offset = instr[IW-5:0], valid with pc_load
//   done         out  1        1-cycle pulse: instruction retired (incl. not-taken branch, NOP)
//   illegal      out  1        1-cycle pulse: undefined opcode retired as NOP
// BEHAVIOUR
//   - Reset (sync, rst=1 at edge): state=IDLE, all outputs and flags 0, except instr_ready=1 from first cycle after reset.
//   - Reset mid-instruction abandons it: no rf_we, done, pc_load or flag update.
//   - Opcodes: 0-7 ALU ADD,SUB,AND,OR,XOR,NOT,MOV,INC; 8 NOP; 9 BRZ; 10 BRN; 11 BRO; 12-15 illegal.
//   - States: IDLE -> DECODE -> EXEC -> WB -> IDLE (ALU ops).
//             IDLE -> DECODE -> BR -> IDLE (9-11).
//             IDLE -> DECODE -> IDLE (8, illegal).
//   - IDLE: instr_ready=1; handshake when instr_valid&instr_ready at edge; instr latched internally; next DECODE.
//   - instr_ready=0 in all other states; instr/instr_valid ignored there.
//   - DECODE: rf_ra/rf_rb/rf_rd/alu_op/alu_mov_sel driven from latched fields.
//     These outputs are held until the next handshake and are unchanged by NOP/branch.
//     NOP/illegal: done (plus illegal) pulse in DECODE, then IDLE.
//   - EXEC: alu_en=1 for exactly EXEC_CYCLES cycles (down-counter), then WB.
//   - WB: alu_en=0, rf_we=1, done=1 for one cycle. Flags sampled from alu_o/z/n at the WB edge.
//     Flags update for ops 0-6; op 7 (INC) leaves flags unchanged.
//   - Latency: ALU op handshake at cycle t -> rf_we/done at t+2+EXEC_CYCLES; next accept at t+3+EXEC_CYCLES.
//   - BR: taken if (BRZ&flag_z)|(BRN&flag_n)|(BRO&flag_o).
//     Taken: pc_load=1 with pc_offset; done=1 either way. Flags unchanged.
//   - Back-to-back: a flag update in WB is visible to a branch whose BR state follows; no forwarding required.
//   - pc_offset, done, illegal, rf_we and pc_load are 0 whenever not pulsing.
// TESTING
//   1 Reset: rst=1 2 cycles mid-EXEC -> all outputs 0, no rf_we; instr_ready=1 first cycle after rst falls.
//   2 ADD rd=3 ra=1 rb=2, ALU returns o=0,z=0,n=1 (EXEC_CYCLES=1)
//     -> alu_en 1 cycle, rf_we+done at t+3 with rf_rd=3, flag_n=1, others 0.
//   3 SUB producing z=1, then BRZ offset 10'h05 back-to-back -> pc_load=1, pc_offset=5, done=1 in BR.
//   4 INC after flags o=1 -> rf_we pulses, flag_o stays 1.
//     Then BRN with flag_n=0 -> pc_load=0, done=1.
//   5 Opcode 13 -> illegal=1 and done=1 in DECODE, no alu_en/rf_we.
//     instr_valid held high through busy states -> exactly one accept per instruction.
//   6 EXEC_CYCLES=3, MOV mov_sel=1 -> alu_en high 3 cycles, alu_mov_sel=1, rf_we at t+5.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Multi-cycle sequencer for the shared ALU and register file: accepts one
// instruction at a time, steps it through decode/exec/writeback or branch.
module alu_op_sequencer #(
   parameter int AW          = 3,
   parameter int EXEC_CYCLES = 1,
   localparam int IW         = 4 + 3*AW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          instr_valid,
   output logic          instr_ready,
   input  logic [IW-1:0] instr,
   output logic [AW-1:0] rf_ra,
   output logic [AW-1:0] rf_rb,
   output logic [AW-1:0] rf_rd,
   output logic          rf_we,
   output logic [2:0]    alu_op,
   output logic          alu_en,
   output logic          alu_mov_sel,
   input  logic          alu_o,
   input  logic          alu_z,
   input  logic          alu_n,
   output logic          flag_o,
   output logic          flag_z,
   output logic          flag_n,
   output logic          pc_load,
   output logic [IW-5:0] pc_offset,
   output logic          done,
   output logic          illegal
);

   // state    | meaning
   // S_IDLE   | waiting for an instruction handshake
   // S_DECODE | fields on outputs; NOP/illegal retire here
   // S_EXEC   | alu_en held for EXEC_CYCLES cycles
   // S_WB     | register write, flag capture, retire
   // S_BR     | branch resolution against stored flags, retire
   typedef enum logic [2:0] {
      S_IDLE,
      S_DECODE,
      S_EXEC,
      S_WB,
      S_BR
   } state_t;

   localparam int EC = (EXEC_CYCLES < 1) ? 1 : EXEC_CYCLES;
   localparam int CW = (EC > 1) ? $clog2(EC) : 1;

   state_t          state_q, state_d;
   logic [IW-1:0]   instr_q;
   logic [CW-1:0]   cnt_q;
   logic [3:0]      op_q;
   logic            is_alu, is_br, taken;

   assign op_q   = instr_q[IW-1 -: 4];
   assign is_alu = ~op_q[3];
   assign is_br  = (op_q == 4'd9) || (op_q == 4'd10) || (op_q == 4'd11);
   assign taken  = ((op_q == 4'd9)  && flag_z) ||
                   ((op_q == 4'd10) && flag_n) ||
                   ((op_q == 4'd11) && flag_o);

   always_comb begin
      state_d     = state_q;
      instr_ready = 1'b0;
      alu_en      = 1'b0;
      rf_we       = 1'b0;
      done        = 1'b0;
      illegal     = 1'b0;
      pc_load     = 1'b0;
      pc_offset   = '0;
      case (state_q)
         S_IDLE: begin
            // ready is masked while reset is held so all outputs read 0
            instr_ready = ~rst;
            if (instr_valid) state_d = S_DECODE;
         end
         S_DECODE: begin
            if (is_alu) begin
               state_d = S_EXEC;
            end else if (is_br) begin
               state_d = S_BR;
            end else begin
               done    = 1'b1;
               illegal = (op_q >= 4'd12);
               state_d = S_IDLE;
            end
         end
         S_EXEC: begin
            alu_en = 1'b1;
            if (cnt_q == '0) state_d = S_WB;
         end
         S_WB: begin
            rf_we   = 1'b1;
            done    = 1'b1;
            state_d = S_IDLE;
         end
         S_BR: begin
            done    = 1'b1;
            pc_load = taken;
            if (taken) pc_offset = instr_q[IW-5:0];
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         instr_q     <= '0;
         cnt_q       <= '0;
         flag_o      <= 1'b0;
         flag_z      <= 1'b0;
         flag_n      <= 1'b0;
         rf_ra       <= '0;
         rf_rb       <= '0;
         rf_rd       <= '0;
         alu_op      <= '0;
         alu_mov_sel <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == S_IDLE && instr_valid) begin
            instr_q <= instr;
            // ALU-facing fields only follow ALU instructions
            if (!instr[IW-1]) begin
               rf_rd       <= instr[IW-5 -: AW];
               rf_ra       <= instr[IW-5-AW -: AW];
               rf_rb       <= instr[AW:1];
               alu_op      <= instr[IW-2 -: 3];
               alu_mov_sel <= instr[0];
            end
         end
         if (state_q == S_DECODE) begin
            cnt_q <= CW'(EC - 1);
         end else if (state_q == S_EXEC && cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
         end
         if (state_q == S_WB && op_q != 4'd7) begin
            flag_o <= alu_o;
            flag_z <= alu_z;
            flag_n <= alu_n;
         end
      end
   end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: two instances (EXEC_CYCLES 1 and 3) share
// stimulus and are compared every cycle against a transaction-age model.
module tb_alu_op_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        instr_valid;
   logic [13:0] instr;
   logic        alu_o, alu_z, alu_n;

   logic        d_ready[2], d_we[2], d_en[2], d_mov[2];
   logic        d_fo[2], d_fz[2], d_fn[2], d_pcl[2], d_done[2], d_ill[2];
   logic [2:0]  d_ra[2], d_rb[2], d_rd[2], d_aop[2];
   logic [9:0]  d_pco[2];

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   alu_op_sequencer #(.AW(3), .EXEC_CYCLES(1)) dut0 (
      .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(d_ready[0]),
      .instr(instr), .rf_ra(d_ra[0]), .rf_rb(d_rb[0]), .rf_rd(d_rd[0]),
      .rf_we(d_we[0]), .alu_op(d_aop[0]), .alu_en(d_en[0]), .alu_mov_sel(d_mov[0]),
      .alu_o(alu_o), .alu_z(alu_z), .alu_n(alu_n),
      .flag_o(d_fo[0]), .flag_z(d_fz[0]), .flag_n(d_fn[0]),
      .pc_load(d_pcl[0]), .pc_offset(d_pco[0]), .done(d_done[0]), .illegal(d_ill[0]));

   alu_op_sequencer #(.AW(3), .EXEC_CYCLES(3)) dut1 (
      .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(d_ready[1]),
      .instr(instr), .rf_ra(d_ra[1]), .rf_rb(d_rb[1]), .rf_rd(d_rd[1]),
      .rf_we(d_we[1]), .alu_op(d_aop[1]), .alu_en(d_en[1]), .alu_mov_sel(d_mov[1]),
      .alu_o(alu_o), .alu_z(alu_z), .alu_n(alu_n),
      .flag_o(d_fo[1]), .flag_z(d_fz[1]), .flag_n(d_fn[1]),
      .pc_load(d_pcl[1]), .pc_offset(d_pco[1]), .done(d_done[1]), .illegal(d_ill[1]));

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
      end
   endtask

   // Model: an accepted instruction retires a fixed number of cycles after
   // acceptance (NOP/illegal 1, branch 2, ALU 2+E); age counts from accept.
   bit         known = 1'b0;
   bit         m_act[2];
   int         m_age[2];
   logic [13:0] m_ins[2];
   logic [2:0] m_ra[2], m_rb[2], m_rd[2], m_aop[2];
   logic       m_mov[2], m_fo[2], m_fz[2], m_fn[2];

   function automatic int ret_age(input int op, input int e);
      if (op < 8) return 2 + e;
      if (op >= 9 && op <= 11) return 2;
      return 1;
   endfunction

   always @(posedge clk) begin
      int e, op;
      for (int k = 0; k < 2; k++) begin
         e  = (k == 0) ? 1 : 3;
         op = int'(m_ins[k][13:10]);
         if (rst) begin
            m_act[k] = 1'b0; m_age[k] = 0; m_ins[k] = '0;
            m_ra[k] = '0; m_rb[k] = '0; m_rd[k] = '0; m_aop[k] = '0; m_mov[k] = 1'b0;
            m_fo[k] = 1'b0; m_fz[k] = 1'b0; m_fn[k] = 1'b0;
         end else if (m_act[k]) begin
            if (m_age[k] == ret_age(op, e)) begin
               if (op < 7) begin
                  m_fo[k] = alu_o; m_fz[k] = alu_z; m_fn[k] = alu_n;
               end
               m_act[k] = 1'b0;
            end else begin
               m_age[k]++;
            end
         end else if (instr_valid) begin
            m_act[k] = 1'b1; m_age[k] = 1; m_ins[k] = instr;
            if (!instr[13]) begin
               m_rd[k] = instr[9:7]; m_ra[k] = instr[6:4]; m_rb[k] = instr[3:1];
               m_aop[k] = instr[12:10]; m_mov[k] = instr[0];
            end
         end
      end
      if (rst) known = 1'b1;
   end

   always @(negedge clk) begin
      int e, op, a;
      bit alu, br, tk, x_pcl;
      if (known) begin
         for (int k = 0; k < 2; k++) begin
            e   = (k == 0) ? 1 : 3;
            op  = int'(m_ins[k][13:10]);
            a   = m_act[k] ? m_age[k] : 0;
            alu = (op < 8);
            br  = (op >= 9 && op <= 11);
            tk  = (op == 9 && m_fz[k]) || (op == 10 && m_fn[k]) || (op == 11 && m_fo[k]);
            x_pcl = br && a == 2 && tk;
            chk($sformatf("d%0d_ready", k), d_ready[k], !rst && !m_act[k]);
            chk($sformatf("d%0d_alu_en", k), d_en[k], alu && a >= 2 && a <= 1 + e);
            chk($sformatf("d%0d_rf_we", k), d_we[k], alu && a == 2 + e);
            chk($sformatf("d%0d_done", k), d_done[k], a != 0 && a == ret_age(op, e));
            chk($sformatf("d%0d_illegal", k), d_ill[k], op >= 12 && a == 1);
            chk($sformatf("d%0d_pc_load", k), d_pcl[k], x_pcl);
            chk($sformatf("d%0d_pc_offset", k), d_pco[k], x_pcl ? m_ins[k][9:0] : 10'd0);
            chk($sformatf("d%0d_fields", k), {d_rd[k], d_ra[k], d_rb[k], d_aop[k], d_mov[k]},
                {m_rd[k], m_ra[k], m_rb[k], m_aop[k], m_mov[k]});
            chk($sformatf("d%0d_flags", k), {d_fo[k], d_fz[k], d_fn[k]},
                {m_fo[k], m_fz[k], m_fn[k]});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; instr_valid = 1'b0;
      tick(); tick();
      rst = 1'b0;
      #1;
   endtask

   task automatic issue(input logic [13:0] w);
      instr = w; instr_valid = 1'b1;
      tick();
      instr_valid = 1'b0;
   endtask

   initial begin
      int acc, wes, en, we_at;
      rst = 1'b1; instr_valid = 1'b0; instr = '0;
      alu_o = 1'b0; alu_z = 1'b0; alu_n = 1'b0;

      // reset mid-EXEC abandons the instruction
      do_reset();
      chk("rst_ready", d_ready[0], 1);
      alu_n = 1'b1;
      issue({4'd0, 3'd3, 3'd1, 3'd2, 1'b0});
      tick();
      chk("rst_pre_exec", d_en[0], 1);
      rst = 1'b1;
      tick();
      chk("rst_c1_outs", {d_ready[0], d_en[0], d_we[0], d_done[0], d_pcl[0], d_fn[0]}, 0);
      tick();
      chk("rst_c2_outs", {d_ready[0], d_en[0], d_we[0], d_done[0], d_pcl[0], d_fn[0]}, 0);
      rst = 1'b0;
      #1;
      chk("rst_ready_after", d_ready[0], 1);

      // ADD rd=3 ra=1 rb=2, ALU reports negative
      do_reset();
      alu_o = 1'b0; alu_z = 1'b0; alu_n = 1'b1;
      issue({4'd0, 3'd3, 3'd1, 3'd2, 1'b0});
      chk("add_fields", {d_rd[0], d_ra[0], d_rb[0], d_aop[0]}, {3'd3, 3'd1, 3'd2, 3'd0});
      chk("add_dec_en", d_en[0], 0);
      tick();
      chk("add_exec_en", d_en[0], 1);
      tick();
      chk("add_wb", {d_en[0], d_we[0], d_done[0], d_rd[0]}, {1'b0, 1'b1, 1'b1, 3'd3});
      tick();
      chk("add_flags", {d_fo[0], d_fz[0], d_fn[0]}, 3'b001);

      // SUB producing zero, BRZ back-to-back
      alu_o = 1'b0; alu_z = 1'b1; alu_n = 1'b0;
      issue({4'd1, 3'd4, 3'd5, 3'd6, 1'b0});
      instr = {4'd9, 10'h005}; instr_valid = 1'b1;
      tick(); tick(); tick(); tick();
      instr_valid = 1'b0;
      chk("brz_flag_z", d_fz[0], 1);
      tick();
      chk("brz_taken", {d_pcl[0], d_pco[0], d_done[0]}, {1'b1, 10'h005, 1'b1});
      chk("brz_rd_held", d_rd[0], 4);
      tick();
      chk("brz_after", {d_pcl[0], d_pco[0]}, 0);

      // INC keeps flags, BRN not taken
      alu_o = 1'b1; alu_z = 1'b0; alu_n = 1'b0;
      issue({4'd0, 3'd1, 3'd2, 3'd3, 1'b0});
      tick(); tick(); tick();
      alu_o = 1'b0; alu_z = 1'b1; alu_n = 1'b1;
      issue({4'd7, 3'd2, 3'd2, 3'd0, 1'b0});
      tick(); tick();
      chk("inc_we", d_we[0], 1);
      tick();
      chk("inc_flags", {d_fo[0], d_fz[0], d_fn[0]}, 3'b100);
      issue({4'd10, 10'h009});
      tick();
      chk("brn_not_taken", {d_pcl[0], d_pco[0], d_done[0]}, {1'b0, 10'h000, 1'b1});
      tick();

      // illegal opcode, then held-valid single accept
      issue({4'd13, 10'h03a});
      chk("ill_decode", {d_ill[0], d_done[0], d_en[0], d_we[0]}, 4'b1100);
      tick();
      instr = {4'd2, 3'd6, 3'd7, 3'd5, 1'b0}; instr_valid = 1'b1;
      acc = 0; wes = 0;
      for (int i = 0; i < 4; i++) begin
         if (d_ready[0]) acc++;
         tick();
         if (d_we[0]) wes++;
      end
      instr_valid = 1'b0;
      chk("held_valid_accepts", acc, 1);
      chk("held_valid_we", wes, 1);
      tick(); tick(); tick(); tick();

      // EXEC_CYCLES=3 MOV from B
      do_reset();
      issue({4'd6, 3'd5, 3'd0, 3'd4, 1'b1});
      chk("mov_sel", d_mov[1], 1);
      en = 0; we_at = 0;
      for (int i = 1; i <= 8; i++) begin
         if (d_en[1]) en++;
         if (d_we[1] && we_at == 0) we_at = i;
         tick();
      end
      chk("mov_en_cycles", en, 3);
      chk("mov_we_at", we_at, 5);

      // random traffic against the model
      for (int i = 0; i < 4000; i++) begin
         rst = ($urandom_range(0, 149) == 0);
         instr_valid = ($urandom_range(0, 3) != 0);
         instr = 14'($urandom);
         alu_o = 1'($urandom); alu_z = 1'($urandom); alu_n = 1'($urandom);
         tick();
      end
      rst = 1'b0; instr_valid = 1'b0;
      tick(); tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
